// File: rtl/regwrite_checker.sv
// Register-writeback checker: compares qualifying register-file writes against a
// preloaded buffer of expected values and reports a pass/fail verdict after halt.
module regwrite_checker #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       NREG      = 8,
    parameter int unsigned       REG_AW    = 3,
    parameter int unsigned       DEPTH     = 32,
    parameter int unsigned       ADDR_W    = 5,
    parameter logic [DATA_W-1:0] HALT_OP   = 16'he000,
    parameter int unsigned       DRAIN_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_wr_en,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic [NREG-1:0]   reg_mask,
    input  logic              start,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] instr,
    output logic [1:0]        state,
    output logic              err_pulse,
    output logic [7:0]        err_count,
    output logic [ADDR_W:0]   chk_count,
    output logic [ADDR_W:0]   exp_count,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act,
    output logic              overflow,
    output logic              done,
    output logic              pass
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned CW  = ADDR_W + 1;
    localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    logic [1:0]        state_nx;
    logic [DCW-1:0]    drain_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] exp_val;
    logic              halt_seen, checking, qual, exhausted, mismatch, clear, push, bad;

    assign halt_seen = (state == S_RUN) && (instr == HALT_OP);
    // The final DRAIN cycle (counter at 0) only moves to DONE; the halt cycle plus
    // DRAIN_CYC-1 drain cycles make up the checked window.
    assign checking  = (state == S_RUN) || ((state == S_DRAIN) && (drain_cnt != '0));
    assign qual      = wb_en && reg_mask[wb_reg];
    assign exhausted = (chk_count == exp_count);
    assign exp_val   = mem[chk_count[ADDR_W-1:0]];
    assign mismatch  = (exp_val != wb_data);
    assign bad       = checking && qual && (exhausted || mismatch);
    assign clear     = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign push      = (state == S_IDLE) && exp_wr_en && (exp_count < CW'(DEPTH));
    assign pass      = done && (err_count == 8'd0) && !overflow && (chk_count == exp_count);

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (instr == HALT_OP) state_nx = S_DRAIN;
            S_DRAIN: if (drain_cnt == '0) state_nx = S_DONE;
            S_DONE:  if (start) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state_nx == S_DONE);
        end
    end

    // Expected-value buffer, contents undefined after reset
    always_ff @(posedge clk) begin
        if (push) mem[exp_count[ADDR_W-1:0]] <= exp_wr_data;
    end

    // Counters, drain timer and first-error capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt     <= '0;
            err_pulse     <= 1'b0;
            err_count     <= 8'd0;
            chk_count     <= '0;
            exp_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_act <= '0;
            overflow      <= 1'b0;
        end else begin
            err_pulse <= bad;
            if (push) exp_count <= exp_count + CW'(1);
            if (halt_seen) drain_cnt <= DCW'(DRAIN_CYC - 1);
            else if ((state == S_DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - DCW'(1);
            if (clear) begin
                chk_count     <= '0;
                err_count     <= 8'd0;
                first_err_idx <= '0;
                first_err_exp <= '0;
                first_err_act <= '0;
                overflow      <= 1'b0;
            end else if (checking && qual) begin
                if (exhausted) overflow <= 1'b1;
                else chk_count <= chk_count + CW'(1);
                if (bad) begin
                    if (err_count != 8'hff) err_count <= err_count + 8'd1;
                    if (err_count == 8'd0) begin
                        first_err_idx <= chk_count[ADDR_W-1:0];
                        first_err_exp <= exhausted ? '0 : exp_val;
                        first_err_act <= wb_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regwrite_checker.sv
// Bench for regwrite_checker: directed plan scenarios plus randomized runs, every
// cycle compared against a cycle-numbered reference model of the check rules.
module tb_regwrite_checker;

    localparam int          DEPTH     = 32;
    localparam int          DRAIN_CYC = 4;
    localparam logic [15:0] HALT      = 16'he000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exp_wr_en = 1'b0;
    logic [15:0] exp_wr_data = 16'h0;
    logic [7:0]  reg_mask = 8'h0;
    logic        start = 1'b0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_reg = 3'd0;
    logic [15:0] wb_data = 16'h0;
    logic [15:0] instr = 16'h0;
    logic [1:0]  state;
    logic        err_pulse, overflow, done, pass;
    logic [7:0]  err_count;
    logic [5:0]  chk_count, exp_count;
    logic [4:0]  first_err_idx;
    logic [15:0] first_err_exp, first_err_act;

    int checks = 0;
    int failures = 0;

    regwrite_checker dut (
        .clk(clk), .rst(rst), .exp_wr_en(exp_wr_en), .exp_wr_data(exp_wr_data),
        .reg_mask(reg_mask), .start(start), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .instr(instr), .state(state), .err_pulse(err_pulse),
        .err_count(err_count), .chk_count(chk_count), .exp_count(exp_count),
        .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
        .first_err_act(first_err_act), .overflow(overflow), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    // Reference model: run phase and the halt edge number decide the check window
    int m_buf[DEPTH];
    int m_state, m_exp, m_chk, m_err, m_idx, m_fexp, m_fact, m_cyc, m_halt;
    bit m_ovf, m_pulse, m_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        m_chk = 0; m_err = 0; m_idx = 0; m_fexp = 0; m_fact = 0; m_ovf = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_state = 0; m_exp = 0; m_pulse = 0; m_done = 0;
    endtask

    task automatic model_edge();
        int  ph;
        bit  bad, in_win;
        int  expv;
        ph = m_state;
        m_cyc++;
        m_pulse = 0;
        in_win = (ph == 1) || (ph == 2 && m_cyc < m_halt + DRAIN_CYC);
        if (ph == 0 && exp_wr_en && m_exp < DEPTH) begin
            m_buf[m_exp] = int'(exp_wr_data);
            m_exp++;
        end
        if ((ph == 0 || ph == 3) && start) begin
            model_clear();
            m_state = 1;
        end else if (in_win && wb_en && reg_mask[wb_reg]) begin
            if (m_chk < m_exp) begin
                expv = m_buf[m_chk];
                bad = (expv != int'(wb_data));
            end else begin
                expv = 0;
                bad = 1;
                m_ovf = 1;
            end
            if (bad) begin
                if (m_err == 0) begin
                    m_idx = m_chk % DEPTH; m_fexp = expv; m_fact = int'(wb_data);
                end
                if (m_err < 255) m_err++;
                m_pulse = 1;
            end
            if (m_chk < m_exp) m_chk++;
        end
        if (ph == 1 && instr == HALT) begin
            m_state = 2;
            m_halt = m_cyc;
        end else if (ph == 2 && m_cyc == m_halt + DRAIN_CYC) begin
            m_state = 3;
        end
        m_done = (m_state == 3);
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_state));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("chk_count", 32'(chk_count), 32'(m_chk));
        chk("exp_count", 32'(exp_count), 32'(m_exp));
        chk("first_err_idx", 32'(first_err_idx), 32'(m_idx));
        chk("first_err_exp", 32'(first_err_exp), 32'(m_fexp));
        chk("first_err_act", 32'(first_err_act), 32'(m_fact));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("done", 32'(done), 32'(m_done));
        chk("pass", 32'(pass), 32'(m_done && m_err == 0 && !m_ovf && m_chk == m_exp));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        exp_wr_en = 1'b0; start = 1'b0; wb_en = 1'b0; instr = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input int v);
        exp_wr_en = 1'b1; exp_wr_data = 16'(v); tick();
    endtask

    task automatic wr(input int r, input int d);
        wb_en = 1'b1; wb_reg = 3'(r); wb_data = 16'(d); tick();
    endtask

    task automatic halt();
        instr = HALT; tick();
    endtask

    task automatic go();
        start = 1'b1; tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("done_within_budget", 32'(done), 32'd1);
    endtask

    initial begin
        do_reset();
        chk("reset_state", 32'(state), 32'd0);

        // Plan 1: matching run passes
        push(1); push(2); push(3);
        reg_mask = 8'h04;
        go();
        wr(2, 1); wr(2, 2); wr(2, 3);
        halt();
        for (int i = 0; i < DRAIN_CYC - 1; i++) tick();
        chk("t1_not_done_early", 32'(done), 32'd0);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_chk_count", 32'(chk_count), 32'd3);

        // Plan 2: single mismatch captured
        do_reset();
        push(1); push(2); push(3);
        go();
        wr(2, 1); wr(2, 5);
        chk("t2_pulse", 32'(err_pulse), 32'd1);
        wr(2, 3);
        chk("t2_pulse_one_cycle", 32'(err_pulse), 32'd0);
        halt(); wait_done();
        chk("t2_err_count", 32'(err_count), 32'd1);
        chk("t2_idx", 32'(first_err_idx), 32'd1);
        chk("t2_exp", 32'(first_err_exp), 32'h0002);
        chk("t2_act", 32'(first_err_act), 32'h0005);
        chk("t2_pass", 32'(pass), 32'd0);

        // Plan 3: buffer exhausted, unmasked register ignored
        do_reset();
        push(10); push(20);
        go();
        wr(2, 10); wr(3, 99); wr(2, 20); wr(3, 7); wr(2, 30);
        halt(); wait_done();
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_err_count", 32'(err_count), 32'd1);
        chk("t3_chk_count", 32'(chk_count), 32'd2);

        // Plan 4: drain window edges
        do_reset();
        push(7); push(8);
        go();
        wr(2, 7);
        halt();
        tick(); tick();
        wr(2, 8);
        wr(2, 9);
        wait_done();
        chk("t4_chk_count", 32'(chk_count), 32'd2);
        chk("t4_pass", 32'(pass), 32'd1);

        // Plan 5: push past depth, then rerun from DONE with retained buffer
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) push(i * 3 + 1);
        chk("t5_exp_count", 32'(exp_count), 32'd32);
        reg_mask = 8'hff;
        go();
        for (int i = 0; i < DEPTH; i++) wr(i % 8, i * 3 + 1);
        halt(); wait_done();
        chk("t5_pass", 32'(pass), 32'd1);
        push(5);
        go();
        chk("t5_rerun_chk_clear", 32'(chk_count), 32'd0);
        chk("t5_rerun_exp_kept", 32'(exp_count), 32'd32);
        for (int i = 0; i < DEPTH; i++) wr(i % 8, i * 3 + 1);
        halt(); wait_done();
        chk("t5_rerun_pass", 32'(pass), 32'd1);

        // Plan 6: async reset mid-drain
        do_reset();
        push(1); go(); wr(2, 1); halt(); tick();
        chk("t6_in_drain", 32'(state), 32'd2);
        do_reset();
        chk("t6_state_after_rst", 32'(state), 32'd0);
        chk("t6_exp_after_rst", 32'(exp_count), 32'd0);

        // Randomized runs, alternating fresh loads and restarts from DONE
        for (int run = 0; run < 8; run++) begin
            int n, len;
            if (run % 2 == 0) begin
                do_reset();
                n = int'($urandom_range(0, DEPTH + 2));
                for (int i = 0; i < n; i++) push(int'($urandom_range(0, 65535)));
            end
            reg_mask = 8'($urandom);
            go();
            len = int'($urandom_range(8, 40));
            for (int i = 0; i < len + DRAIN_CYC + 1; i++) begin
                wb_en = 1'($urandom);
                wb_reg = 3'($urandom);
                if (($urandom_range(0, 3) != 0) && m_chk < m_exp) wb_data = 16'(m_buf[m_chk]);
                else wb_data = 16'($urandom);
                exp_wr_en = 1'($urandom);
                exp_wr_data = 16'($urandom);
                start = ($urandom_range(0, 7) == 0);
                if (i == len) instr = HALT;
                else instr = 16'($urandom_range(0, 16'hdfff));
                tick();
            end
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
